// File: rtl/pe_alu_issue.sv
// Single-issue operand fetch / issue / writeback stage in front of the PE ALU.
// Holds an 8x32 register file (r0 reads as zero) and executes LI locally.
module pe_alu_issue #(
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned NREG    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [1:0]  instr_op,
   input  logic [2:0]  instr_rd,
   input  logic [2:0]  instr_rs1,
   input  logic [2:0]  instr_rs2,
   input  logic [31:0] instr_imm,
   output logic        alu_op_sel,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   output logic        wb_valid,
   output logic [2:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        busy,
   input  logic [2:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_LI  = 2'b10;
   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  rd_q, rd_d;
   logic [31:0] rf_q [NREG];
   logic [31:0] rf_d [NREG];
   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic        alu_op_sel_q, alu_op_sel_d;
   logic        wb_valid_q, wb_valid_d;
   logic [2:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;

   always_comb begin
      // NOTE: every _d starts from a default so no path leaves it unassigned (no latches).
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_d         = rd_q;
      rf_d         = rf_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_sel_d = alu_op_sel_q;
      wb_valid_d   = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               case (instr_op)
                  OP_ADD, OP_AND: begin
                     alu_a_d      = rf_q[instr_rs1];
                     alu_b_d      = rf_q[instr_rs2];
                     alu_op_sel_d = instr_op[0];
                     rd_d         = instr_rd;
                     cnt_d        = '0;
                     state_d      = S_EXEC;
                  end
                  OP_LI: begin
                     if (instr_rd != 3'd0) rf_d[instr_rd] = instr_imm;
                     wb_valid_d = 1'b1;
                     wb_rd_d    = instr_rd;
                     wb_data_d  = instr_imm;
                  end
                  default: ;
               endcase
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAT_M1) state_d = S_WB;
         end
         S_WB: begin
            // r0 stays zero; the strobe still reports the computed value.
            if (rd_q != 3'd0) rf_d[rd_q] = alu_result;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = alu_result;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         rd_q         <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_sel_q <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         // NOTE: the register file is architecturally zero after reset, so it is reset here.
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rd_q         <= rd_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_sel_q <= alu_op_sel_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign busy        = !instr_ready;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op_sel  = alu_op_sel_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_pe_alu_issue.sv
// Bench for pe_alu_issue: two instances (ALU_LAT=1 and 3) run the same program in
// lockstep against registered ALU models; a scoreboard checks every writeback.
module tb_pe_alu_issue;

   typedef struct {
      logic [2:0]  rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  instr_op = '0;
   logic [2:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
   logic [31:0] instr_imm = '0;
   logic [2:0]  dbg_addr = '0;
   logic        v1 = 1'b0, v3 = 1'b0;

   logic        rdy1, sel1, wbv1, busy1;
   logic [31:0] a1, b1, res1, wbd1, dbg1;
   logic [2:0]  wbr1;
   logic        rdy3, sel3, wbv3, busy3;
   logic [31:0] a3, b3, wbd3, dbg3;
   logic [2:0]  wbr3;
   logic [31:0] p3 [3];

   int checks = 0, errors = 0, cyc = 0;
   exp_t q1[$], q3[$];
   logic [31:0] m [2][8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Registered ALU models of latency 1 and 3.
   always @(posedge clk) res1 <= sel1 ? (a1 & b1) : (a1 + b1);
   always @(posedge clk) begin
      p3[0] <= sel3 ? (a3 & b3) : (a3 + b3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   pe_alu_issue #(.ALU_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr_ready(rdy1),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
      .instr_rs2(instr_rs2), .instr_imm(instr_imm), .alu_op_sel(sel1),
      .alu_a(a1), .alu_b(b1), .alu_result(res1), .wb_valid(wbv1),
      .wb_rd(wbr1), .wb_data(wbd1), .busy(busy1), .dbg_addr(dbg_addr),
      .dbg_data(dbg1));

   pe_alu_issue #(.ALU_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .instr_valid(v3), .instr_ready(rdy3),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
      .instr_rs2(instr_rs2), .instr_imm(instr_imm), .alu_op_sel(sel3),
      .alu_a(a3), .alu_b(b3), .alu_result(p3[2]), .wb_valid(wbv3),
      .wb_rd(wbr3), .wb_data(wbd3), .busy(busy3), .dbg_addr(dbg_addr),
      .dbg_data(dbg3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard monitors: every strobe must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && wbv1) begin
         if (q1.size() == 0) check("wb1_unexpected", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            check("wb1_rd", 32'(wbr1), 32'(e.rd));
            check("wb1_data", wbd1, e.data);
            check("wb1_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && wbv3) begin
         if (q3.size() == 0) check("wb3_unexpected", 32'd1, 32'd0);
         else begin
            e = q3.pop_front();
            check("wb3_rd", 32'(wbr3), 32'(e.rd));
            check("wb3_data", wbd3, e.data);
            check("wb3_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Called at the negedge before the accepting edge: predicts the writeback.
   task automatic model_accept(input int d, input int lat,
                               output logic [31:0] ea, output logic [31:0] eb);
      exp_t e;
      ea = m[d][instr_rs1];
      eb = m[d][instr_rs2];
      e.rd = instr_rd;
      e.data = '0;
      e.cyc = 0;
      if (instr_op != 2'b11) begin
         if (instr_op == 2'b10) begin
            e.data = instr_imm;
            e.cyc  = cyc + 1;
         end else begin
            e.data = instr_op[0] ? (ea & eb) : (ea + eb);
            e.cyc  = cyc + 1 + lat + 1;
         end
         if (instr_rd != 3'd0) m[d][instr_rd] = e.data;
         if (d == 0) q1.push_back(e);
         else q3.push_back(e);
      end
   endtask

   // Starts and ends at a negedge; valid stays up until each DUT has taken it.
   task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [31:0] imm, input bit chk_hold);
      bit p1 = 1'b1, p3b = 1'b1, acc1 = 1'b0, acc3 = 1'b0;
      int w1 = 0, w3 = 0, guard = 0;
      logic [31:0] ea1, eb1, ea3, eb3;
      instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
      v1 = 1'b1;
      v3 = 1'b1;
      while (p1 || p3b) begin
         if (p1) begin
            if (rdy1) begin
               model_accept(0, 1, ea1, eb1);
               acc1 = 1'b1;
               p1 = 1'b0;
               if (chk_hold) begin
                  check("hold1_wait", 32'(w1), 32'd2);
                  check("hold1_in_wb_cycle", 32'(wbv1), 32'd1);
               end
            end else begin
               w1++;
               check("busy1_while_stalled", 32'(busy1), 32'd1);
            end
         end
         if (p3b) begin
            if (rdy3) begin
               model_accept(1, 3, ea3, eb3);
               acc3 = 1'b1;
               p3b = 1'b0;
               if (chk_hold) begin
                  check("hold3_wait", 32'(w3), 32'd4);
                  check("hold3_in_wb_cycle", 32'(wbv3), 32'd1);
               end
            end else begin
               w3++;
               check("busy3_while_stalled", 32'(busy3), 32'd1);
            end
         end
         @(posedge clk);
         @(negedge clk);
         if (acc1 && !op[1]) begin
            check("alu1_a", a1, ea1);
            check("alu1_b", b1, eb1);
            check("alu1_op_sel", 32'(sel1), 32'(op[0]));
         end
         if (acc3 && !op[1]) begin
            check("alu3_a", a3, ea3);
            check("alu3_b", b3, eb3);
            check("alu3_op_sel", 32'(sel3), 32'(op[0]));
         end
         acc1 = 1'b0;
         acc3 = 1'b0;
         v1 = p1;
         v3 = p3b;
         guard++;
         if (guard > 40) begin
            check("issue_timeout", 32'd1, 32'd0);
            v1 = 1'b0;
            v3 = 1'b0;
            break;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q1.size() != 0 || q3.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 32'(q1.size() + q3.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic dbg_all();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check("dbg1_reg", dbg1, m[0][i]);
         check("dbg3_reg", dbg3, m[1][i]);
      end
      @(negedge clk);
   endtask

   task automatic reg_is(input logic [2:0] idx, input logic [31:0] val);
      dbg_addr = idx;
      #1;
      check("reg1_const", dbg1, val);
      check("reg3_const", dbg3, val);
   endtask

   initial begin
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 8; i++) m[d][i] = '0;

      #2;
      check("rst_alu_a", a1 | a3, 32'd0);
      check("rst_alu_b", b1 | b3, 32'd0);
      check("rst_op_sel", 32'(sel1 | sel3), 32'd0);
      check("rst_wb_valid", 32'(wbv1 | wbv3), 32'd0);
      check("rst_wb_rd", 32'(wbr1 | wbr3), 32'd0);
      check("rst_wb_data", wbd1 | wbd3, 32'd0);
      check("rst_busy", 32'(busy1 | busy3), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'({rdy1, rdy3}), 32'd3);

      issue(2'b10, 3'd1, 3'd0, 3'd0, 32'd15, 1'b0);
      issue(2'b10, 3'd2, 3'd0, 3'd0, 32'd17, 1'b0);
      issue(2'b00, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0);
      issue(2'b01, 3'd4, 3'd1, 3'd2, 32'd0, 1'b1);
      issue(2'b10, 3'd5, 3'd0, 3'd0, 32'hFFFF_FFFF, 1'b0);
      issue(2'b10, 3'd6, 3'd0, 3'd0, 32'd1, 1'b0);
      issue(2'b00, 3'd7, 3'd5, 3'd6, 32'd0, 1'b0);
      issue(2'b10, 3'd0, 3'd0, 3'd0, 32'h1234, 1'b1);
      issue(2'b00, 3'd1, 3'd0, 3'd2, 32'd0, 1'b0);
      drain();
      reg_is(3'd3, 32'd32);
      reg_is(3'd4, 32'd1);
      reg_is(3'd7, 32'd0);
      reg_is(3'd0, 32'd0);
      reg_is(3'd1, 32'd17);
      @(negedge clk);
      dbg_all();

      // Reset while both instances are in EXEC.
      issue(2'b00, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0);
      check("exec_busy", 32'({busy1, busy3}), 32'd3);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'({busy1, busy3}), 32'd0);
      check("midrst_wb_valid", 32'({wbv1, wbv3}), 32'd0);
      q1.delete();
      q3.delete();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 8; i++) m[d][i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("ready_after_midrst", 32'({rdy1, rdy3}), 32'd3);
      dbg_all();
      issue(2'b11, 3'd5, 3'd1, 3'd2, 32'hDEAD_BEEF, 1'b0);
      repeat (5) @(negedge clk);
      check("nop_ready", 32'({rdy1, rdy3}), 32'd3);
      dbg_all();
      check("final_queue_empty", 32'(q1.size() + q3.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
